// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side types and constants.
package rv_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, exposing head entry and occupancy.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Flush discards everything, including a same-cycle push.
  assign do_pop  = pop & (count_q != '0) & ~flush;
  assign do_push = push & (count_q != CW'(DEPTH)) & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: issues imem reads from the PC, tracks in-flight requests,
// buffers returned words with their PC and hands them to decode.
module instr_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = rv_fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_enable,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   tag_count, out_count;
  logic [CW:0]     occ;
  logic [XLEN-1:0] tag_head;
  logic [EW-1:0]   out_head_raw;
  fetch_entry_t    out_head, out_push;
  logic            pop, issue, resp_any, resp_live, resp_keep;

  assign pop       = if_valid & if_ready;
  assign occ       = {1'b0, inflight_q} + {1'b0, out_count};

  assign imem_req_valid = ~rst & ~redirect_valid & ((occ - (CW+1)'(pop)) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_addr;
  assign issue          = imem_req_valid & imem_req_ready;

  assign pc_enable = ~rst & (issue | redirect_valid);
  assign pc_next   = redirect_valid ? redirect_target : pc_addr + XLEN'(INSTR_BYTES);

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_any  = imem_resp_valid & (inflight_q != '0);
  assign resp_live = resp_any & (drop_q == '0);
  // A live response arriving with a redirect is already stale.
  assign resp_keep = resp_live & ~redirect_valid;

  assign out_push = '{pc: tag_head, instr: imem_resp_data};

  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(resp_any);
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Every request still outstanding after this cycle belongs to the old stream.
      drop_d = inflight_q - CW'(resp_any);
    end else if (resp_any && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc_addr),
    .pop       (resp_live),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data (out_push),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (out_head_raw),
    .count     (out_count)
  );

  assign out_head = out_head_raw;
  assign if_valid = (out_count != '0);
  assign if_instr = if_valid ? out_head.instr : NOP;
  assign if_pc    = if_valid ? out_head.pc : RESET_PC;

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight_q != '0));
  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ <= (CW+1)'(DEPTH));
  // Tags exist only for requests whose responses will be kept.
  a_tag_track: assert property (@(posedge clk) disable iff (rst)
    tag_count == (inflight_q - drop_q));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a PC register and an in-order
// memory whose words are the bitwise complement of their address.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int exp_pc;
  int ndeliv;
  int lat_max;
  bit lat_rand;
  int issue_cnt = 0;
  int cyc = 0;
  int i0, d0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  instr_fetch_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_addr         (pc_addr),
    .pc_enable       (pc_enable),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc_addr <= 32'h0;
    else if (pc_enable) pc_addr <= pc_next;
  end

  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) issue_cnt <= issue_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_resp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready)
        mq.push_back('{a: imem_req_addr,
                       due: cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_max)});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= ~mq[0].a;
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check any handshake in the current cycle, then advance to the next one.
  task automatic step();
    #1;
    if (if_valid && if_ready) begin
      chk("deliver_pc", if_pc, exp_pc);
      chk("deliver_instr", if_instr, ~exp_pc);
      exp_pc += 4;
      ndeliv++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 0;
    ndeliv = 0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_max = 1;
    lat_rand = 1'b0;
    exp_pc = 0;
    ndeliv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_enable", 32'(pc_enable), 32'd0);

    // Streaming at one instruction per cycle after a two-cycle fill.
    rst = 1'b0;
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    chk("t1_pc_enable", 32'(pc_enable), 32'd1);
    chk("t1_pc_next", pc_next, 32'h4);
    repeat (20) step();
    chk("t1_count", ndeliv, 32'd18);

    // Decode stall from empty fills exactly DEPTH slots.
    if_ready = 1'b0;
    do_reset();
    i0 = issue_cnt;
    repeat (10) step();
    chk("t2_issues", issue_cnt - i0, 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_pc_enable", 32'(pc_enable), 32'd0);
    chk("t2_pc_held", pc_addr, 32'h10);
    chk("t2_if_valid", 32'(if_valid), 32'd1);
    chk("t2_if_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    repeat (12) step();
    chk("t2_drained", ndeliv, 32'd12);
    chk("t2_next_pc", exp_pc, 32'h30);

    // Memory stall holds the PC and request address.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_pc_enable", 32'(pc_enable), 32'd0);
      chk("t3_req_addr", imem_req_addr, 32'h40);
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    chk("t3_resume_en", 32'(pc_enable), 32'd1);
    chk("t3_resume_addr", imem_req_addr, 32'h40);
    chk("t3_resume_next", pc_next, 32'h44);
    repeat (10) step();

    // Redirect with two slow fetches outstanding.
    lat_max = 4;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    #1;
    chk("t4_no_req", 32'(imem_req_valid), 32'd0);
    chk("t4_pc_enable", 32'(pc_enable), 32'd1);
    chk("t4_pc_next", pc_next, 32'h100);
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'h100;
    #1;
    chk("t4_pc_addr", pc_addr, 32'h100);
    chk("t4_req_addr", imem_req_addr, 32'h100);
    chk("t4_if_valid", 32'(if_valid), 32'd0);
    repeat (15) step();
    chk("t4_delivered", 32'(ndeliv > 0), 32'd1);

    // Redirect coinciding with a pop and a response.
    lat_max = 1;
    do_reset();
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    #1;
    chk("t5_if_valid", 32'(if_valid), 32'd1);
    chk("t5_if_pc", if_pc, 32'hc);
    chk("t5_resp", 32'(imem_resp_valid), 32'd1);
    chk("t5_no_req", 32'(imem_req_valid), 32'd0);
    chk("t5_pc_next", pc_next, 32'h200);
    step();
    redirect_valid = 1'b0;
    exp_pc = 32'h200;
    d0 = ndeliv;
    #1;
    chk("t5_flushed", 32'(if_valid), 32'd0);
    step();
    chk("t5_fill", 32'(if_valid), 32'd0);
    repeat (6) step();
    chk("t5_count", ndeliv - d0, 32'd5);
    chk("t5_next_pc", exp_pc, 32'h214);

    // Random latency and back-pressure against the in-order PC model.
    lat_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("t6_occ", 32'((dut.inflight_q + dut.out_count) <= DEPTH), 32'd1);
      step();
    end
    chk("t6_delivered", 32'(ndeliv > 0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
